// File: rtl/fpu_pkg.sv
// Shared definitions for the add/subtract FPU: controller states, status bit
// positions and the exponent bias derivation.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } fpu_state_e;

    localparam int STAT_ZERO = 0;
    localparam int STAT_OVF  = 1;
    localparam int STAT_UNF  = 2;
    localparam int STAT_INX  = 3;
    localparam int STAT_W    = 4;

    function automatic int fpu_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fpu_lzc #(
    parameter  int W  = 26,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_in,
    output logic [CW-1:0] count
);

    // Ascending scan so the most significant set bit writes last and wins.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data_in[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor: capture, align, add, normalise,
// then hold the result until the consumer takes it.
module fpu_addsub
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 6,
    parameter  int MAN_W = 25,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    localparam int MW   = MAN_W + 1;               // mantissa with hidden one
    localparam int SW   = MAN_W + 2;               // sum width, room for carry
    localparam int LZW  = $clog2(MW + 1);
    localparam int EW   = EXP_W + LZW + 2;         // signed normalisation exponent
    localparam int BIAS = fpu_bias(EXP_W);
    localparam logic signed [EW-1:0] EXP_MAX = EW'(2 * BIAS + 1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid stays high with data held until out_ready is seen.
    fpu_state_e state_q, state_d;

    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic               sub_q, sub_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MW-1:0]      big_man_q, big_man_d, small_man_q, small_man_d;
    logic               sign_q, sign_d;
    logic               eff_sub_q, eff_sub_d;
    logic               inexact_q, inexact_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [W-1:0]       data_q, data_d;
    logic [STAT_W-1:0]  status_q, status_d;

    logic [EXP_W-1:0]   a_exp, b_exp, big_exp, small_exp, exp_diff;
    logic [MW-1:0]      a_man, b_man, big_man, small_man, shifted;
    logic               b_sign_eff, a_ge, lost_align, lost_norm;
    logic [LZW-1:0]     lz;
    logic signed [EW-1:0] norm_exp;
    logic [MW-1:0]      norm_man;

    fpu_lzc #(.W(MW)) u_lzc (
        .data_in (sum_q[MW-1:0]),
        .count   (lz)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign data_out   = data_q;
    assign status_out = status_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        exp_d       = exp_q;
        big_man_d   = big_man_q;
        small_man_d = small_man_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        inexact_d   = inexact_q;
        sum_d       = sum_q;
        data_d      = data_q;
        status_d    = status_q;

        // Exponent field zero means a zero operand, whatever the mantissa holds.
        a_exp      = a_q[W-2:MAN_W];
        b_exp      = b_q[W-2:MAN_W];
        a_man      = (a_exp == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
        b_man      = (b_exp == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
        b_sign_eff = b_q[W-1] ^ sub_q;
        a_ge       = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));
        big_exp    = a_ge ? a_exp : b_exp;
        small_exp  = a_ge ? b_exp : a_exp;
        big_man    = a_ge ? a_man : b_man;
        small_man  = a_ge ? b_man : a_man;
        exp_diff   = big_exp - small_exp;
        if (int'(exp_diff) >= MW) begin
            shifted    = '0;
            lost_align = |small_man;
        end else begin
            shifted    = small_man >> exp_diff;
            lost_align = |(small_man & ~({MW{1'b1}} << exp_diff));
        end

        // Carry-out shifts right by one; otherwise shift left past leading zeros.
        if (sum_q[SW-1]) begin
            norm_exp  = EW'(exp_q) + EXP_ONE;
            norm_man  = sum_q[SW-1:1];
            lost_norm = sum_q[0];
        end else begin
            norm_exp  = EW'(exp_q) - EW'(lz);
            norm_man  = sum_q[MW-1:0] << lz;
            lost_norm = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = op_A_in;
                    b_d     = op_B_in;
                    sub_d   = op_sub;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                exp_d       = big_exp;
                big_man_d   = big_man;
                small_man_d = shifted;
                sign_d      = a_ge ? a_q[W-1] : b_sign_eff;
                eff_sub_d   = a_q[W-1] ^ b_sign_eff;
                inexact_d   = lost_align;
                state_d     = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, big_man_q} - {1'b0, small_man_q})
                                    : ({1'b0, big_man_q} + {1'b0, small_man_q});
                state_d = ST_NORM;
            end
            ST_NORM: begin
                status_d           = '0;
                status_d[STAT_INX] = inexact_q | lost_norm;
                if (sum_q == '0) begin
                    data_d              = '0;
                    status_d[STAT_ZERO] = 1'b1;
                end else if (norm_exp >= EXP_MAX) begin
                    data_d             = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    status_d[STAT_OVF] = 1'b1;
                end else if (norm_exp < EXP_ONE) begin
                    data_d              = '0;
                    status_d[STAT_UNF]  = 1'b1;
                    status_d[STAT_ZERO] = 1'b1;
                end else begin
                    data_d = {sign_q, norm_exp[EXP_W-1:0], norm_man[MAN_W-1:0]};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            exp_q       <= '0;
            big_man_q   <= '0;
            small_man_q <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            inexact_q   <= 1'b0;
            sum_q       <= '0;
            data_q      <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            exp_q       <= exp_d;
            big_man_q   <= big_man_d;
            small_man_q <= small_man_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            inexact_q   <= inexact_d;
            sum_q       <= sum_d;
            data_q      <= data_d;
            status_q    <= status_d;
        end
    end

endmodule
